game_flow_controller: RTL

- Top-level game sequencer for the FlippyBit game logic.
- Replaces the fixed 3-lane state machine with a parametrised controller: any number of lanes, a lives counter, saturating score, level tracking, high score, timed feedback states.
- Consumes per-lane `correct` / `game_over` strobes from the lane logic.
- Drives per-lane clear pulses, the game state, and the score/level/lives values used by the display logic.

---
 rtl/game_pkg.sv | 22 ++
 rtl/lane_popcount.sv | 19 +
 rtl/game_flow_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared state encoding and field widths for the FlippyBit game sequencer.
package game_pkg;

  localparam int STATE_W   = 3;
  localparam int LIVES_W   = 4;
  localparam int LEVEL_W   = 4;
  localparam int LEVEL_MAX = 15;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_CELEBRATE = 3'd3,
    ST_PENALTY   = 3'd4,
    ST_OVER      = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lane_popcount.sv
// Combinational count of asserted lane strobes.
module lane_popcount #(
  parameter int NUM_LANES = 3
) (
  input  logic [NUM_LANES-1:0]             lanes,
  output logic [$clog2(NUM_LANES+1)-1:0]   count
);

  localparam int CNT_W = $clog2(NUM_LANES + 1);

  // NOTE: count is assigned before the loop so every path drives it and no latch is inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      count = count + CNT_W'(lanes[i]);
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: start/clear/run/feedback/over flow with lives, saturating score,
// level tracking and high score, driven by per-lane correct/game_over strobes.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int NUM_LANES    = 3,
  parameter int SCORE_WIDTH  = 8,
  parameter int LIVES        = 3,
  parameter int HOLD_CYCLES  = 4,
  parameter int RESET_CYCLES = 2,
  parameter int LEVEL_STEP   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_button,
  input  logic [NUM_LANES-1:0]   correct,
  input  logic [NUM_LANES-1:0]   game_over,
  output logic [NUM_LANES-1:0]   lane_clear,
  output logic [STATE_W-1:0]     state,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SCORE_WIDTH-1:0] high_score,
  output logic [LIVES_W-1:0]     lives_left,
  output logic [LEVEL_W-1:0]     level
);

  localparam int PC_W    = $clog2(NUM_LANES + 1);
  localparam int SUM_W   = max_int(SCORE_WIDTH, PC_W) + 1;
  localparam int LIFE_W  = max_int(LIVES_W, PC_W);
  localparam int LC_W    = $clog2(LEVEL_STEP + NUM_LANES + 1);
  localparam int CNT_MAX = max_int(HOLD_CYCLES, RESET_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [SUM_W-1:0]   SCORE_MAX  = SUM_W'({SCORE_WIDTH{1'b1}});
  localparam logic [LC_W:0]      STEP_C     = (LC_W+1)'(LEVEL_STEP);
  localparam logic [LC_W:0]      LC_MAX     = (LC_W+1)'({LC_W{1'b1}});
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(LEVEL_MAX);
  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CLEAR_LOAD = CNT_W'(RESET_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt;
  logic [LC_W-1:0]    lvl_cnt;
  logic               start_q;
  logic               start_pulse;
  logic               restart;
  logic [NUM_LANES-1:0] eff_hits;
  logic [PC_W-1:0]    hits;
  logic [PC_W-1:0]    misses;

  logic [SUM_W-1:0]       score_sum;
  logic [SCORE_WIDTH-1:0] score_next;
  logic [SCORE_WIDTH-1:0] high_next;
  logic [LIVES_W-1:0]     lives_next;
  logic [LC_W:0]          lvl_sum;
  logic [LC_W:0]          lvl_wrap;
  logic [LC_W-1:0]        lvl_next;
  logic                   level_up;

  assign state       = state_q;
  assign start_pulse = start_button & ~start_q;
  assign restart     = start_pulse &&
                       (state_q == ST_IDLE || state_q == ST_RUNNING || state_q == ST_OVER);

  // game_over wins on a lane that reports both strobes in the same cycle.
  assign eff_hits = correct & ~game_over;

  lane_popcount #(.NUM_LANES(NUM_LANES)) u_hit_count (
    .lanes (eff_hits),
    .count (hits)
  );

  lane_popcount #(.NUM_LANES(NUM_LANES)) u_miss_count (
    .lanes (game_over),
    .count (misses)
  );

  assign score_sum  = SUM_W'(score) + SUM_W'(hits);
  assign score_next = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_WIDTH-1:0];
  assign high_next  = (score_next > high_score) ? score_next : high_score;
  assign lives_next = (LIFE_W'(misses) >= LIFE_W'(lives_left)) ? '0
                    : LIVES_W'(LIFE_W'(lives_left) - LIFE_W'(misses));

  // At most one level per cycle; any excess stays in the counter for later.
  assign lvl_sum  = (LC_W+1)'(lvl_cnt) + (LC_W+1)'(hits);
  assign level_up = (lvl_sum >= STEP_C);
  assign lvl_wrap = level_up ? (lvl_sum - STEP_C) : lvl_sum;
  assign lvl_next = (lvl_wrap > LC_MAX) ? '1 : lvl_wrap[LC_W-1:0];

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      score      <= '0;
      high_score <= '0;
      lives_left <= LIVES_INIT;
      level      <= '0;
      lvl_cnt    <= '0;
      cnt        <= '0;
      start_q    <= 1'b0;
      lane_clear <= '1;
    end else begin
      start_q <= start_button;
      if (restart) begin
        state_q    <= ST_CLEAR;
        cnt        <= CLEAR_LOAD;
        score      <= '0;
        lives_left <= LIVES_INIT;
        level      <= '0;
        lvl_cnt    <= '0;
        lane_clear <= '1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            lane_clear <= '1;
          end
          ST_CLEAR: begin
            if (cnt == '0) begin
              state_q    <= ST_RUNNING;
              lane_clear <= '0;
            end else begin
              cnt        <= cnt - 1'b1;
              lane_clear <= '1;
            end
          end
          ST_RUNNING: begin
            lane_clear <= correct | game_over;
            if (hits != '0) begin
              score   <= score_next;
              lvl_cnt <= lvl_next;
              if (level_up && level != LEVEL_TOP) level <= level + 1'b1;
            end
            if (misses != '0) begin
              lives_left <= lives_next;
              if (lives_next == '0) begin
                state_q    <= ST_OVER;
                lane_clear <= '1;
                high_score <= high_next;
              end else begin
                state_q <= ST_PENALTY;
                cnt     <= HOLD_LOAD;
              end
            end else if (hits != '0) begin
              state_q <= ST_CELEBRATE;
              cnt     <= HOLD_LOAD;
            end
          end
          ST_CELEBRATE, ST_PENALTY: begin
            lane_clear <= '0;
            if (cnt == '0) state_q <= ST_RUNNING;
            else           cnt     <= cnt - 1'b1;
          end
          ST_OVER: begin
            lane_clear <= '1;
          end
          default: begin
            state_q    <= ST_IDLE;
            lane_clear <= '1;
          end
        endcase
      end
    end
  end

endmodule
